// File: rtl/me_pkg.sv
// Shared types and sizes for the motion-estimation frame loader.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package me_pkg;

    localparam int PIX_W          = 8;
    localparam int REF_AW         = 8;
    localparam int SRCH_AW        = 10;
    localparam int CNT_W          = 10;
    localparam int TMR_W          = 13;

    localparam int REF_BYTES      = 256;
    localparam int SRCH_BYTES     = 1024;
    localparam int FRAME_BYTES    = 1280;
    localparam int TIMEOUT_CYCLES = 4200;

    typedef enum logic [1:0] {
        LOAD_REF  = 2'd0,
        LOAD_SRCH = 2'd1,
        RUN       = 2'd2,
        RESULT    = 2'd3
    } me_state_e;

endpackage

// File: rtl/me_search_store.sv
// Search-window pixel store: 1024x8, one synchronous write port, two combinational read ports.
// Latency: write lands on the rising edge; reads are zero-cycle (same-cycle write returns old data).
// Backpressure: none; the store always accepts a write.
// Ports: clk; wr_en/wr_addr/wr_data write port; rd_addr1/rd_data1 and rd_addr2/rd_data2 read ports.
module me_search_store
    import me_pkg::*;
(
    input  logic               clk,
    input  logic               wr_en,
    input  logic [SRCH_AW-1:0] wr_addr,
    input  logic [PIX_W-1:0]   wr_data,
    input  logic [SRCH_AW-1:0] rd_addr1,
    input  logic [SRCH_AW-1:0] rd_addr2,
    output logic [PIX_W-1:0]   rd_data1,
    output logic [PIX_W-1:0]   rd_data2
);

    // Pixel contents are deliberately not reset.
    logic [PIX_W-1:0] mem [SRCH_BYTES];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    assign rd_data1 = mem[rd_addr1];
    assign rd_data2 = mem[rd_addr2];

endmodule

// File: rtl/me_frame_loader.sv
// Loads a 256-byte reference block and 1024-byte search window, runs the ME engine, holds its result.
// Latency: start_signal rises one cycle after the last byte's state change; result captured on the done cycle.
// Backpressure: s_ready low outside loading; result held on res_* until res_ready.
// Ports: clk, rst (async active-high); s_valid/s_ready/s_data/s_last byte stream;
//        address_ref/address_search1/address_search2 -> ref_data/search_data1/search_data2 engine reads;
//        start_signal, process_completed, best_distance, motion_vector_x/y engine handshake;
//        res_valid/res_ready/res_distance/res_mv_x/res_mv_y result; err one-cycle error pulse.
// Optional feature: define ME_LOADER_TIMEOUT_EN to abort RUN after TIMEOUT_CYCLES with a 0xFF result.
module me_frame_loader
    import me_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               s_valid,
    output logic               s_ready,
    input  logic [PIX_W-1:0]   s_data,
    input  logic               s_last,
    input  logic [REF_AW-1:0]  address_ref,
    input  logic [SRCH_AW-1:0] address_search1,
    input  logic [SRCH_AW-1:0] address_search2,
    output logic [PIX_W-1:0]   ref_data,
    output logic [PIX_W-1:0]   search_data1,
    output logic [PIX_W-1:0]   search_data2,
    output logic               start_signal,
    input  logic               process_completed,
    input  logic [7:0]         best_distance,
    input  logic [3:0]         motion_vector_x,
    input  logic [3:0]         motion_vector_y,
    output logic               res_valid,
    input  logic               res_ready,
    output logic [7:0]         res_distance,
    output logic [3:0]         res_mv_x,
    output logic [3:0]         res_mv_y,
    output logic               err
);

    localparam logic [CNT_W-1:0] REF_LAST  = CNT_W'(REF_BYTES - 1);
    localparam logic [CNT_W-1:0] SRCH_LAST = CNT_W'(FRAME_BYTES - REF_BYTES - 1);

    me_state_e        state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             start_q, start_d;
    logic             err_q, err_d;
    logic [7:0]       res_dist_q, res_dist_d;
    logic [3:0]       res_mvx_q, res_mvx_d;
    logic [3:0]       res_mvy_q, res_mvy_d;
`ifdef ME_LOADER_TIMEOUT_EN
    logic [TMR_W-1:0] timer_q, timer_d;
`endif

    logic             accept;
    logic             last_pos;
    logic [PIX_W-1:0] ref_mem [REF_BYTES];

    assign s_ready  = (state_q == LOAD_REF) || (state_q == LOAD_SRCH);
    assign accept   = s_valid && s_ready;
    // Frame byte 1279 is search-window byte 1023.
    assign last_pos = (cnt_q == SRCH_LAST);

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        err_d      = 1'b0;
        res_dist_d = res_dist_q;
        res_mvx_d  = res_mvx_q;
        res_mvy_d  = res_mvy_q;
`ifdef ME_LOADER_TIMEOUT_EN
        timer_d    = '0;
`endif
        case (state_q)
            LOAD_REF: begin
                if (accept) begin
                    // s_last can never be legal inside the reference block.
                    if (s_last) begin
                        err_d = 1'b1;
                        cnt_d = '0;
                    end else if (cnt_q == REF_LAST) begin
                        state_d = LOAD_SRCH;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + 10'd1;
                    end
                end
            end
            LOAD_SRCH: begin
                if (accept) begin
                    if (s_last != last_pos) begin
                        err_d   = 1'b1;
                        cnt_d   = '0;
                        state_d = LOAD_REF;
                    end else if (last_pos) begin
                        state_d = RUN;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + 10'd1;
                    end
                end
            end
            RUN: begin
                // Only trust done while our run request is actually visible to the engine.
                if (process_completed && start_q) begin
                    res_dist_d = best_distance;
                    res_mvx_d  = motion_vector_x;
                    res_mvy_d  = motion_vector_y;
                    state_d    = RESULT;
                end
`ifdef ME_LOADER_TIMEOUT_EN
                else if (timer_q == TMR_W'(TIMEOUT_CYCLES - 1)) begin
                    err_d      = 1'b1;
                    res_dist_d = 8'hFF;
                    res_mvx_d  = 4'h0;
                    res_mvy_d  = 4'h0;
                    state_d    = RESULT;
                end else begin
                    timer_d = timer_q + 13'd1;
                end
`endif
            end
            RESULT: begin
                if (res_ready) begin
                    state_d = LOAD_REF;
                end
            end
            default: state_d = LOAD_REF;
        endcase
        // High only while RUN persists, so it rises one cycle after entry and drops with the exit edge.
        start_d = (state_q == RUN) && (state_d == RUN);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= LOAD_REF;
            cnt_q      <= '0;
            start_q    <= 1'b0;
            err_q      <= 1'b0;
            res_dist_q <= 8'h00;
            res_mvx_q  <= 4'h0;
            res_mvy_q  <= 4'h0;
`ifdef ME_LOADER_TIMEOUT_EN
            timer_q    <= '0;
`endif
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            start_q    <= start_d;
            err_q      <= err_d;
            res_dist_q <= res_dist_d;
            res_mvx_q  <= res_mvx_d;
            res_mvy_q  <= res_mvy_d;
`ifdef ME_LOADER_TIMEOUT_EN
            timer_q    <= timer_d;
`endif
        end
    end

    // Reference block store; contents survive reset.
    always_ff @(posedge clk) begin
        if (accept && (state_q == LOAD_REF)) begin
            ref_mem[cnt_q[REF_AW-1:0]] <= s_data;
        end
    end

    assign ref_data = ref_mem[address_ref];

    me_search_store u_search_store (
        .clk      (clk),
        .wr_en    (accept && (state_q == LOAD_SRCH)),
        .wr_addr  (cnt_q),
        .wr_data  (s_data),
        .rd_addr1 (address_search1),
        .rd_addr2 (address_search2),
        .rd_data1 (search_data1),
        .rd_data2 (search_data2)
    );

    assign start_signal = start_q;
    assign err          = err_q;
    assign res_valid    = (state_q == RESULT);
    assign res_distance = res_dist_q;
    assign res_mv_x     = res_mvx_q;
    assign res_mv_y     = res_mvy_q;

endmodule

// File: tb/tb_me_frame_loader.sv
// Directed bench for me_frame_loader: byte-stream loading, store readback, result handshake, error frames.
// Latency: checks sampled on the falling edge, inputs driven on the falling edge.
// Backpressure: exercises s_valid gaps and a held res_ready=0 window.
module tb_me_frame_loader;

    logic       clk = 1'b0;
    logic       rst;
    logic       s_valid, s_ready, s_last;
    logic [7:0] s_data;
    logic [7:0] address_ref;
    logic [9:0] address_search1, address_search2;
    logic [7:0] ref_data, search_data1, search_data2;
    logic       start_signal, process_completed;
    logic [7:0] best_distance;
    logic [3:0] motion_vector_x, motion_vector_y;
    logic       res_valid, res_ready;
    logic [7:0] res_distance;
    logic [3:0] res_mv_x, res_mv_y;
    logic       err;

    int n_chk  = 0;
    int n_fail = 0;

    logic [7:0]  ref_m  [256];
    logic [7:0]  srch_m [1024];
    logic [15:0] exp_q  [$];

    always #5 clk = ~clk;

    me_frame_loader dut (
        .clk               (clk),
        .rst               (rst),
        .s_valid           (s_valid),
        .s_ready           (s_ready),
        .s_data            (s_data),
        .s_last            (s_last),
        .address_ref       (address_ref),
        .address_search1   (address_search1),
        .address_search2   (address_search2),
        .ref_data          (ref_data),
        .search_data1      (search_data1),
        .search_data2      (search_data2),
        .start_signal      (start_signal),
        .process_completed (process_completed),
        .best_distance     (best_distance),
        .motion_vector_x   (motion_vector_x),
        .motion_vector_y   (motion_vector_y),
        .res_valid         (res_valid),
        .res_ready         (res_ready),
        .res_distance      (res_distance),
        .res_mv_x          (res_mv_x),
        .res_mv_y          (res_mv_y),
        .err               (err)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] pix(input int pat, input int idx);
        logic [7:0] b;
        b = 8'(idx);
        return (pat == 0) ? b : (b ^ 8'h5A);
    endfunction

    // Streams n bytes; s_last on byte last_at (-1: never). Returns on the falling edge
    // after the final byte was taken, with s_valid dropped.
    task automatic stream(input int n, input int last_at, input int pat, input bit rnd);
        int idx   = 0;
        int guard = 0;
        logic v;
        while (idx < n && guard < 20000) begin
            @(negedge clk);
            guard++;
            v       = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            s_valid = v;
            s_data  = pix(pat, idx);
            s_last  = (idx == last_at);
            if (v && s_ready) begin
                if (idx < 256) ref_m[idx] = pix(pat, idx);
                else           srch_m[idx - 256] = pix(pat, idx);
                idx++;
            end
        end
        @(negedge clk);
        s_valid = 1'b0;
        s_last  = 1'b0;
        chk("stream_bytes_taken", idx, n);
    endtask

    task automatic check_stores(input string tag);
        int bad_r = 0;
        int bad_s = 0;
        for (int a = 0; a < 256; a++) begin
            address_ref = 8'(a);
            #1;
            if (ref_data !== ref_m[a]) bad_r++;
        end
        for (int a = 0; a < 1024; a++) begin
            address_search1 = 10'(a);
            address_search2 = 10'(1023 - a);
            #1;
            if (search_data1 !== srch_m[a])        bad_s++;
            if (search_data2 !== srch_m[1023 - a]) bad_s++;
        end
        chk({tag, "_ref_bad_addrs"}, bad_r, 0);
        chk({tag, "_srch_bad_addrs"}, bad_s, 0);
    endtask

    // Called on a falling edge while in RUN with start_signal high.
    task automatic drive_result(input logic [7:0] d, input logic [3:0] x, input logic [3:0] y);
        process_completed = 1'b1;
        best_distance     = d;
        motion_vector_x   = x;
        motion_vector_y   = y;
        exp_q.push_back({d, x, y});
        @(negedge clk);
        process_completed = 1'b0;
        best_distance     = 8'h00;
        motion_vector_x   = 4'h0;
        motion_vector_y   = 4'h0;
    endtask

    task automatic take_result(input string tag);
        int n = 0;
        logic [15:0] e;
        while (res_valid !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_res_valid"}, res_valid, 1'b1);
        e = (exp_q.size() > 0) ? exp_q.pop_front() : 16'hxxxx;
        chk({tag, "_res_fields"}, {res_distance, res_mv_x, res_mv_y}, e);
    endtask

    task automatic release_result(input string tag);
        res_ready = 1'b1;
        @(negedge clk);
        res_ready = 1'b0;
        chk({tag, "_res_valid_low"}, res_valid, 1'b0);
        chk({tag, "_s_ready_back"}, s_ready, 1'b1);
    endtask

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; s_valid = 1'b0; s_data = 8'h00; s_last = 1'b0;
        address_ref = 8'h00; address_search1 = 10'h000; address_search2 = 10'h000;
        process_completed = 1'b0; best_distance = 8'h00;
        motion_vector_x = 4'h0; motion_vector_y = 4'h0; res_ready = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // Reset state
        chk("rst_s_ready", s_ready, 1'b1);
        chk("rst_start", start_signal, 1'b0);
        chk("rst_res_valid", res_valid, 1'b0);
        chk("rst_res_distance", res_distance, 8'h00);
        chk("rst_res_mv", {res_mv_x, res_mv_y}, 8'h00);
        chk("rst_err", err, 1'b0);

        // Frame A: bytes i&FF, s_last on 1279
        stream(1280, 1279, 0, 1'b0);
        chk("a_err_quiet", err, 1'b0);
        chk("a_s_ready_run", s_ready, 1'b0);
        chk("a_start_at_entry", start_signal, 1'b0);
        @(negedge clk);
        chk("a_start_rise", start_signal, 1'b1);
        address_ref = 8'd5; address_search1 = 10'd0; address_search2 = 10'd1023;
        #1;
        chk("a_ref5", ref_data, 8'h05);
        chk("a_search0", search_data1, 8'h00);
        chk("a_search1023", search_data2, 8'hFF);
        check_stores("a");
        @(negedge clk);
        chk("a_start_held", start_signal, 1'b1);
        chk("a_no_result_yet", res_valid, 1'b0);

        drive_result(8'h23, 4'h3, 4'hE);
        take_result("a");
        chk("a_start_dropped", start_signal, 1'b0);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("a_hold_fields", {res_distance, res_mv_x, res_mv_y}, 16'h233E);
            chk("a_hold_valid", res_valid, 1'b1);
            chk("a_hold_s_ready", s_ready, 1'b0);
        end
        release_result("a");

        // Early s_last on frame byte 700
        stream(701, 700, 0, 1'b0);
        chk("early_err_pulse", err, 1'b1);
        chk("early_s_ready", s_ready, 1'b1);
        @(negedge clk);
        chk("early_err_cleared", err, 1'b0);
        chk("early_s_ready_hold", s_ready, 1'b1);

        // Missing s_last on byte 1279
        stream(1280, -1, 0, 1'b0);
        chk("nolast_err_pulse", err, 1'b1);
        chk("nolast_s_ready", s_ready, 1'b1);
        @(negedge clk);
        chk("nolast_err_cleared", err, 1'b0);

        // Frame B: different pattern, must load from byte 0 again
        stream(1280, 1279, 1, 1'b0);
        chk("b_s_ready_run", s_ready, 1'b0);
        @(negedge clk);
        chk("b_start_rise", start_signal, 1'b1);
        check_stores("b");
        @(negedge clk);
`ifndef ME_LOADER_TIMEOUT_EN
        repeat (50) @(negedge clk);
        chk("b_run_persists_start", start_signal, 1'b1);
        chk("b_run_persists_valid", res_valid, 1'b0);
`endif
        drive_result(8'h5C, 4'hA, 4'h1);
        take_result("b");
        release_result("b");

        // Frame C: random s_valid gaps, same data as frame A
        stream(1280, 1279, 0, 1'b1);
`ifdef ME_LOADER_TIMEOUT_EN
        begin
            int n = 0;
            while (err !== 1'b1 && n < 6000) begin
                @(negedge clk);
                n++;
            end
            chk("to_cycles_to_err", n, 4200);
            exp_q.push_back(16'hFF00);
            take_result("to");
            @(negedge clk);
            chk("to_err_one_cycle", err, 1'b0);
        end
        check_stores("c");
        release_result("to");
        stream(1280, 1279, 1, 1'b0);
        @(negedge clk);
`else
        check_stores("c");
        @(negedge clk);
`endif

        // Reset in the middle of RUN
        chk("mid_run_start_before", start_signal, 1'b1);
        @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        chk("rst_run_start_async", start_signal, 1'b0);
        chk("rst_run_res_valid", res_valid, 1'b0);
        chk("rst_run_s_ready", s_ready, 1'b1);
        @(negedge clk);
        rst = 1'b0;
        address_ref = 8'd200;
        #1;
        chk("rst_keeps_ref_store", ref_data, ref_m[200]);
        chk("scoreboard_drained", exp_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/me_frame_loader.md
ME_FRAME_LOADER -- requirements
Module: me_frame_loader

Interface
REQ-001 SHALL have one clock and an asynchronous, active-high reset; ports listed in REQ-002..REQ-019 (clock and reset first).
REQ-002 clk  in  1  sole clock; all state updates on rising edge.
REQ-003 rst  in  1  asynchronous, active-high reset.
REQ-004 s_valid  in  1  upstream byte-stream valid.
REQ-005 s_ready  out  1  loader accepts byte when s_valid && s_ready.
REQ-006 s_data  in  8  pixel byte; bytes 0..255 = reference block, 256..1279 = search window, raster order.
REQ-007 s_last  in  1  marks final byte of a frame (must coincide with byte 1279).
REQ-008 address_ref  in  8  engine read address, reference store.
REQ-009 address_search1, address_search2  in  10 each  engine read addresses, search store.
REQ-010 ref_data  out  8  ref store contents at address_ref, combinational.
REQ-011 search_data1, search_data2  out  8 each  search store contents at respective addresses, combinational.
REQ-012 start_signal  out  1  run request to motion-estimation engine.
REQ-013 process_completed  in  1  engine done flag.
REQ-014 best_distance  in  8  engine minimum SAD.
REQ-015 motion_vector_x, motion_vector_y  in  4 each  engine winning vector.
REQ-016 res_valid  out  1  result available.
REQ-017 res_ready  in  1  result consumer ready.
REQ-018 res_distance  out  8; res_mv_x, res_mv_y  out  4 each  captured result.
REQ-019 err  out  1  one-cycle pulse on frame-length error or timeout.

Function
REQ-020 FSM states SHALL be LOAD_REF, LOAD_SRCH, RUN, RESULT.
REQ-021 s_ready SHALL be 1 exactly in LOAD_REF and LOAD_SRCH; 0 in RUN and RESULT.
REQ-022 Each accepted byte SHALL be written at byte counter cnt (10 bit): LOAD_REF -> ref[cnt[7:0]], LOAD_SRCH -> search[cnt]; cnt increments per accepted byte.
REQ-023 LOAD_REF -> LOAD_SRCH on 256th accepted byte, cnt cleared to 0.
REQ-024 LOAD_SRCH -> RUN on 1024th accepted byte when s_last=1; cnt cleared.
REQ-025 s_last=1 on any byte other than frame byte 1279, or s_last=0 on byte 1279: err pulses next cycle, cnt cleared, FSM -> LOAD_REF (frame discarded; the offending byte is still written).
REQ-026 start_signal SHALL be 1 only in RUN, registered (rises cycle after RUN entry).
REQ-027 In RUN, on cycle process_completed=1 with start_signal=1: capture best_distance, motion_vector_x/y into res_* regs; FSM -> RESULT.
REQ-028 res_valid SHALL be 1 only in RESULT; res_* stable while res_valid=1 and res_ready=0.
REQ-029 RESULT -> LOAD_REF on res_valid && res_ready; res_valid low the following cycle.
REQ-030 Reads SHALL be purely combinational from storage; writes in same cycle as a read to same address return old data.

Reset
REQ-031 On rst: FSM=LOAD_REF, cnt=0, start_signal=0, res_valid=0, res_distance=8'h00, res_mv_x=res_mv_y=4'h0, err=0; s_ready=1 after release.
REQ-032 Storage contents SHALL NOT be reset; rst mid-load or mid-run aborts operation immediately (start_signal drops asynchronously).

Configuration
REQ-033 Macro ME_LOADER_TIMEOUT_EN: when defined, 13-bit timer counts RUN cycles; on reaching TIMEOUT_CYCLES (4200) without process_completed, err pulses, res_distance=8'hFF, res_mv_x=res_mv_y=4'h0, FSM -> RESULT.
REQ-034 Without ME_LOADER_TIMEOUT_EN: no timer logic; RUN persists until process_completed.

Structure
REQ-035 Shared package me_pkg SHALL hold state enum, REF_BYTES=256, SRCH_BYTES=1024, FRAME_BYTES=1280, TIMEOUT_CYCLES=4200, address/pixel width constants.
REQ-036 One sub-module me_search_store: 1024x8 array, one write port, two combinational read ports; reference store is a 256x8 array inline.

Verification
REQ-037 Stream bytes i&8'hFF for i=0..1279, s_last on 1279 -> ref[5]=5, search[0]=0x00 (byte 256), search[1023]=0xFF; start_signal=1 one cycle after RUN entry.
REQ-038 RUN, drive process_completed=1, best_distance=8'h23, mv=(4'h3,4'hE) -> res_valid=1, res_distance=0x23, res_mv_x=3, res_mv_y=0xE, start_signal=0.
REQ-039 Hold res_ready=0 for 10 cycles -> res_* unchanged, s_ready=0; res_ready=1 -> next cycle FSM LOAD_REF, s_ready=1.
REQ-040 s_last on byte 700 -> err one-cycle pulse, s_ready stays 1, next frame loads from cnt=0 correctly.
REQ-041 Toggle s_valid randomly 50% during load -> identical store contents to REQ-037.
REQ-042 With ME_LOADER_TIMEOUT_EN, never assert process_completed -> err pulse 4200 cycles after RUN entry, res_distance=0xFF; assert rst mid-RUN -> start_signal=0 immediately, res_valid=0.
